hdmi_period_scheduler: RTL and testbench
========================================

// Module: hdmi_period_scheduler
// PURPOSE
//  Owns raster timing for the HDMI TX path. Runs on the pixel clock and labels every pixel with its
//  TMDS period type: control, video preamble/guard, active video, or data-island preamble/guard/packet.
//  Pulls InfoFrame/audio packets from an upstream packet source over a valid/ready handshake and places
//  them in horizontal blanking. Sits between the packet source and the TMDS encoders feeding ddr_diff.
// PARAMETERS
//  H_ACTIVE 1280 visible px/line;  H_FP 110;  H_SYNC 40;  H_BP 220  (H_TOTAL = sum = 1650)
//  V_ACTIVE 720 visible lines;     V_FP 5;    V_SYNC 5;   V_BP 20   (V_TOTAL = sum = 750)
//  SYNC_POS 1   sync active level (1 = active-high)
//  DI_START 1284  h at which a data-island preamble may begin (must be >= H_ACTIVE)
//  MAX_PKTS 18  max packets per island; FIT = min(MAX_PKTS, (H_TOTAL-DI_START-34)/32); FIT<1 = elab error
// PORTS
//  clk_i      in   1   pixel clock
//  reset      in   1   asynchronous, active-high
//  pkt_valid  in   1   upstream has a packet ready; held until consumed by pkt_ready
//  pkt_ready  out  1   1-cycle pulse on px 0 of each packet slot = packet consumed
//  pkt_px     out  5   pixel index 0..31 within current packet slot (0 outside DI_DATA)
//  mode       out  3   0 CTRL,1 VID_PRE,2 VID_GB,3 VIDEO,4 DI_PRE,5 DI_GB_LEAD,6 DI_DATA,7 DI_GB_TRAIL
//  ctl        out  4   CTL3..0: 4'b0001 in VID_PRE, 4'b0101 in DI_PRE, else 4'b0000
//  hsync      out  1   horizontal sync at SYNC_POS level
//  vsync      out  1   vertical sync at SYNC_POS level
//  de         out  1   1 iff mode==VIDEO
//  h_cnt      out  11  pixel column of current outputs, 0..H_TOTAL-1
//  v_cnt      out  10  line of current outputs, 0..V_TOTAL-1
// BEHAVIOUR
//  - All outputs registered; every output in a cycle describes pixel (h_cnt,v_cnt).
//  - Reset (async): h_cnt=0, v_cnt=0, mode=CTRL, ctl=0, de=0, pkt_ready=0, pkt_px=0, hsync=vsync=~SYNC_POS.
//    First cycle after release shows h=0,v=0 as VIDEO (line 0 entered without preamble). Reset mid-island
//    aborts it immediately; no further pkt_ready.
//  - h wraps H_TOTAL-1 -> 0 and increments v; v wraps V_TOTAL-1 -> 0.
//  - VIDEO: h<H_ACTIVE and v<V_ACTIVE.  hsync: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//    vsync: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, whole lines (changes at h=0).
//  - Video preamble/guard only when the next line is active ((v+1) mod V_TOTAL < V_ACTIVE):
//    VID_PRE for h=H_TOTAL-10..H_TOTAL-3, VID_GB for h=H_TOTAL-2..H_TOTAL-1.
//  - Island FSM: IDLE -> PRE(8) -> GB_LEAD(2) -> DATA(32 per slot) -> GB_TRAIL(2) -> IDLE.
//    Start: first DI_PRE cycle at h=DI_START iff pkt_valid high in the previous cycle; otherwise no island
//    this line. Allowed on every line (active and blanking).
//    pkt_ready pulses on pkt_px=0 of every slot. After slot k (pkt_px=31): another slot iff pkt_valid
//    high in that cycle and k+1<FIT; else GB_TRAIL. At most FIT packets per line; leftovers wait a line.
//    Island plus 12 CTRL px always end before VID_PRE (guaranteed by FIT).
//  - pkt_valid deassertion without pkt_ready is a protocol error; scheduler simply ends the island.
//  - Modes mutually exclusive; pixels in no other period are CTRL.
// TESTING
//  1 Reset release, pkt_valid=0: VIDEO at (0,0); de high 1280 px/line for 720 lines; hsync high h=1390..1429;
//    vsync high lines 725..729; frame = 1,237,500 cycles.
//  2 Line 719->720: no VID_PRE/VID_GB at end of 719; on line 749, VID_PRE h=1640..1647 ctl=0001, VID_GB 1648..1649.
//  3 pkt_valid held high: island every line: DI_PRE h=1284..1291 ctl=0101, GB 1292..1293, 10 slots
//    1294..1613, GB_TRAIL 1614..1615; exactly 10 pkt_ready pulses per line.
//  4 Source offers 3 packets (drops valid after 3rd pkt_ready): 3 slots, GB_TRAIL at h=1390..1391, CTRL to 1639.
//  5 pkt_valid rises at h=1285: no island this line; island starts h=1284 next line.
//  6 Assert reset during slot 2 of an island: outputs return to reset values same cycle; after release
//    scheduling resumes at (0,0) with no stale pkt_ready.

Source files
------------

// File: rtl/hdmi_period_scheduler.sv
// Raster timing and TMDS period labelling for the HDMI TX path; places upstream
// packets into horizontal blanking as data islands.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POS = 1'b1,
    parameter int DI_START = 1284,
    parameter int MAX_PKTS = 18
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    output logic [4:0]  pkt_px,
    output logic [2:0]  mode,
    output logic [3:0]  ctl,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] h_cnt,
    output logic [9:0]  v_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FIT_RAW = (H_TOTAL - DI_START - 34) / 32;
    localparam int FIT     = (MAX_PKTS < FIT_RAW) ? MAX_PKTS : FIT_RAW;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VP_BEG  = 11'(H_TOTAL - 10);
    localparam logic [10:0] VG_BEG  = 11'(H_TOTAL - 2);
    localparam logic [10:0] DI_H    = 11'(DI_START);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [4:0]  FIT_L   = 5'(FIT);

    // Output period codes
    localparam logic [2:0] M_CTRL     = 3'd0;
    localparam logic [2:0] M_VID_PRE  = 3'd1;
    localparam logic [2:0] M_VID_GB   = 3'd2;
    localparam logic [2:0] M_VIDEO    = 3'd3;
    localparam logic [2:0] M_DI_PRE   = 3'd4;
    localparam logic [2:0] M_DI_GBL   = 3'd5;
    localparam logic [2:0] M_DI_DATA  = 3'd6;
    localparam logic [2:0] M_DI_GBT   = 3'd7;

    // Island FSM states
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_GBL  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GBT  = 3'd4;

    if (DI_START < H_ACTIVE) begin : g_bad_di_start
        $error("DI_START must not fall inside active video");
    end
    if (FIT < 1) begin : g_bad_fit
        $error("no data-island packet fits in horizontal blanking");
    end

    logic        run;
    logic [2:0]  di_state;
    logic [2:0]  di_cnt;
    logic [4:0]  slot;

    logic [10:0] h_n;
    logic [9:0]  v_n;
    logic [9:0]  v_after;
    logic        next_line_act;
    logic        video_n;

    logic [2:0]  st_n;
    logic [2:0]  cnt_n;
    logic [4:0]  slot_n;
    logic [4:0]  px_n;
    logic        ready_n;

    logic [2:0]  mode_n;
    logic [3:0]  ctl_n;
    logic        hsync_n;
    logic        vsync_n;

    // The first edge after reset reloads pixel (0,0) so line 0 starts as video
    // without a preamble; counting proceeds from the second edge on.
    always_comb begin
        h_n = h_cnt;
        v_n = v_cnt;
        if (!run) begin
            h_n = '0;
            v_n = '0;
        end else if (h_cnt == H_LAST) begin
            h_n = '0;
            v_n = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_n = h_cnt + 11'd1;
        end
    end

    always_comb begin
        v_after       = (v_n == V_LAST) ? '0 : v_n + 10'd1;
        next_line_act = (v_after < V_ACT_L);
        video_n       = (h_n < H_ACT_L) && (v_n < V_ACT_L);
        hsync_n       = ((h_n >= HS_BEG) && (h_n < HS_END)) ? SYNC_POS : ~SYNC_POS;
        vsync_n       = ((v_n >= VS_BEG) && (v_n < VS_END)) ? SYNC_POS : ~SYNC_POS;
    end

    always_comb begin
        st_n    = di_state;
        cnt_n   = di_cnt;
        slot_n  = slot;
        px_n    = '0;
        ready_n = 1'b0;
        case (di_state)
            S_IDLE: begin
                if (run && (h_n == DI_H) && pkt_valid) begin
                    st_n  = S_PRE;
                    cnt_n = '0;
                end
            end
            S_PRE: begin
                if (di_cnt == 3'd7) begin
                    st_n  = S_GBL;
                    cnt_n = '0;
                end else begin
                    cnt_n = di_cnt + 3'd1;
                end
            end
            S_GBL: begin
                if (di_cnt == 3'd1) begin
                    st_n    = S_DATA;
                    slot_n  = '0;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = di_cnt + 3'd1;
                end
            end
            S_DATA: begin
                if (pkt_px == 5'd31) begin
                    if (pkt_valid && ((slot + 5'd1) < FIT_L)) begin
                        slot_n  = slot + 5'd1;
                        ready_n = 1'b1;
                    end else begin
                        st_n  = S_GBT;
                        cnt_n = '0;
                    end
                end else begin
                    px_n = pkt_px + 5'd1;
                end
            end
            S_GBT: begin
                if (di_cnt == 3'd1) begin
                    st_n = S_IDLE;
                end else begin
                    cnt_n = di_cnt + 3'd1;
                end
            end
            default: st_n = S_IDLE;
        endcase
    end

    always_comb begin
        mode_n = M_CTRL;
        if (video_n) begin
            mode_n = M_VIDEO;
        end else begin
            case (st_n)
                S_PRE:   mode_n = M_DI_PRE;
                S_GBL:   mode_n = M_DI_GBL;
                S_DATA:  mode_n = M_DI_DATA;
                S_GBT:   mode_n = M_DI_GBT;
                default: begin
                    if (next_line_act && (h_n >= VG_BEG)) begin
                        mode_n = M_VID_GB;
                    end else if (next_line_act && (h_n >= VP_BEG)) begin
                        mode_n = M_VID_PRE;
                    end
                end
            endcase
        end
        case (mode_n)
            M_VID_PRE: ctl_n = 4'b0001;
            M_DI_PRE:  ctl_n = 4'b0101;
            default:   ctl_n = 4'b0000;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            run       <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            di_state  <= S_IDLE;
            di_cnt    <= '0;
            slot      <= '0;
            pkt_px    <= '0;
            pkt_ready <= 1'b0;
            mode      <= M_CTRL;
            ctl       <= '0;
            de        <= 1'b0;
            hsync     <= ~SYNC_POS;
            vsync     <= ~SYNC_POS;
        end else begin
            run       <= 1'b1;
            h_cnt     <= h_n;
            v_cnt     <= v_n;
            di_state  <= st_n;
            di_cnt    <= cnt_n;
            slot      <= slot_n;
            pkt_px    <= (st_n == S_DATA) ? px_n : 5'd0;
            pkt_ready <= ready_n;
            mode      <= mode_n;
            ctl       <= ctl_n;
            de        <= video_n;
            hsync     <= hsync_n;
            vsync     <= vsync_n;
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler: default horizontal timing, short frame.
module tb_hdmi_period_scheduler;

    localparam int HT = 1650;
    localparam int VT = 8;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [4:0]  pkt_px;
    logic [2:0]  mode;
    logic [3:0]  ctl;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;

    hdmi_period_scheduler #(
        .V_ACTIVE(4),
        .V_FP(1),
        .V_SYNC(2),
        .V_BP(1)
    ) dut (
        .clk_i(clk_i),
        .reset(reset),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_px(pkt_px),
        .mode(mode),
        .ctl(ctl),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [36:0] vec;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   rdy_q[$];
    int   cyc = -1;
    int   checks = 0;
    int   errors = 0;

    // Cycle index since the last reset release: after edge k the outputs describe pixel k.
    always @(posedge clk_i or posedge reset) begin
        if (reset) cyc <= -1;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input int c, input logic [2:0] m, input logic [3:0] cl,
                       input logic hs, input logic vs, input logic rdy,
                       input logic [4:0] px, input string nm);
        exp_t e;
        logic [10:0] h;
        logic [9:0]  v;
        if (c < 0) begin
            h = '0;
            v = '0;
        end else begin
            h = 11'(c % HT);
            v = 10'((c / HT) % VT);
        end
        e.cyc  = c;
        e.vec  = {h, v, m, cl, (m == 3'd3), hs, vs, rdy, px};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 100000) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc actual=%0d required=%0d", cyc, n);
        end
    endtask

    // Monitor: compare checkpoint pixels and every pkt_ready pulse.
    always @(negedge clk_i) begin : monitor
        logic [36:0] act;
        exp_t e;
        int   r;
        act = {h_cnt, v_cnt, mode, ctl, de, hsync, vsync, pkt_ready, pkt_px};
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%h required=%h", e.name, cyc, act, e.vec);
            end
        end
        if (pkt_ready === 1'b1) begin
            checks++;
            if (rdy_q.size() == 0) begin
                errors++;
                $display("FAIL pkt_ready_unexpected actual_cyc=%0d required=none", cyc);
            end else begin
                r = rdy_q.pop_front();
                if (r != cyc) begin
                    errors++;
                    $display("FAIL pkt_ready_time actual_cyc=%0d required_cyc=%0d", cyc, r);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        // Reset values, then first frame with no packets offered
        chk(-1, 3'd0, 4'h0, 0, 0, 0, 5'd0, "reset_values");
        chk(0,     3'd3, 4'h0, 0, 0, 0, 5'd0, "video_0_0");
        chk(1279,  3'd3, 4'h0, 0, 0, 0, 5'd0, "video_last_px");
        chk(1280,  3'd0, 4'h0, 0, 0, 0, 5'd0, "ctrl_after_video");
        chk(1389,  3'd0, 4'h0, 0, 0, 0, 5'd0, "hsync_before");
        chk(1390,  3'd0, 4'h0, 1, 0, 0, 5'd0, "hsync_first");
        chk(1429,  3'd0, 4'h0, 1, 0, 0, 5'd0, "hsync_last");
        chk(1430,  3'd0, 4'h0, 0, 0, 0, 5'd0, "hsync_after");
        chk(1639,  3'd0, 4'h0, 0, 0, 0, 5'd0, "ctrl_before_vpre");
        chk(1640,  3'd1, 4'h1, 0, 0, 0, 5'd0, "vid_pre_first");
        chk(1647,  3'd1, 4'h1, 0, 0, 0, 5'd0, "vid_pre_last");
        chk(1648,  3'd2, 4'h0, 0, 0, 0, 5'd0, "vid_gb_first");
        chk(1649,  3'd2, 4'h0, 0, 0, 0, 5'd0, "vid_gb_last");
        chk(1650,  3'd3, 4'h0, 0, 0, 0, 5'd0, "video_0_1");
        chk(6590,  3'd0, 4'h0, 0, 0, 0, 5'd0, "no_vpre_last_active");
        chk(6598,  3'd0, 4'h0, 0, 0, 0, 5'd0, "no_vgb_last_active");
        chk(6600,  3'd0, 4'h0, 0, 0, 0, 5'd0, "blank_line_start");
        chk(8249,  3'd0, 4'h0, 0, 0, 0, 5'd0, "vsync_before");
        chk(8250,  3'd0, 4'h0, 0, 1, 0, 5'd0, "vsync_first");
        chk(11549, 3'd0, 4'h0, 0, 1, 0, 5'd0, "vsync_last");
        chk(11550, 3'd0, 4'h0, 0, 0, 0, 5'd0, "vsync_after");
        chk(12940, 3'd0, 4'h0, 1, 0, 0, 5'd0, "hsync_blank_line");
        chk(13190, 3'd1, 4'h1, 0, 0, 0, 5'd0, "vid_pre_frame_end");
        chk(13197, 3'd1, 4'h1, 0, 0, 0, 5'd0, "vid_pre_frame_end_last");
        chk(13198, 3'd2, 4'h0, 0, 0, 0, 5'd0, "vid_gb_frame_end");
        chk(13199, 3'd2, 4'h0, 0, 0, 0, 5'd0, "vid_gb_frame_end_last");
        chk(13200, 3'd3, 4'h0, 0, 0, 0, 5'd0, "frame_wrap");
        repeat (3) @(posedge clk_i);
        #1 reset = 1'b0;

        // pkt_valid held high for lines 0..5 of the second frame
        wait_cyc(13200);
        b = 13200;
        chk(b + 1283, 3'd0, 4'h0, 0, 0, 0, 5'd0,  "di_before_pre");
        chk(b + 1284, 3'd4, 4'h5, 0, 0, 0, 5'd0,  "di_pre_first");
        chk(b + 1291, 3'd4, 4'h5, 0, 0, 0, 5'd0,  "di_pre_last");
        chk(b + 1292, 3'd5, 4'h0, 0, 0, 0, 5'd0,  "di_gb_lead_first");
        chk(b + 1293, 3'd5, 4'h0, 0, 0, 0, 5'd0,  "di_gb_lead_last");
        chk(b + 1294, 3'd6, 4'h0, 0, 0, 1, 5'd0,  "slot0_px0");
        chk(b + 1295, 3'd6, 4'h0, 0, 0, 0, 5'd1,  "slot0_px1");
        chk(b + 1325, 3'd6, 4'h0, 0, 0, 0, 5'd31, "slot0_px31");
        chk(b + 1326, 3'd6, 4'h0, 0, 0, 1, 5'd0,  "slot1_px0");
        chk(b + 1390, 3'd6, 4'h0, 1, 0, 1, 5'd0,  "slot3_px0_hsync");
        chk(b + 1613, 3'd6, 4'h0, 0, 0, 0, 5'd31, "slot9_px31");
        chk(b + 1614, 3'd7, 4'h0, 0, 0, 0, 5'd0,  "di_gb_trail_first");
        chk(b + 1615, 3'd7, 4'h0, 0, 0, 0, 5'd0,  "di_gb_trail_last");
        chk(b + 1616, 3'd0, 4'h0, 0, 0, 0, 5'd0,  "ctrl_after_island");
        chk(b + 1640, 3'd1, 4'h1, 0, 0, 0, 5'd0,  "vid_pre_after_island");
        chk(b + 8250 + 1284, 3'd4, 4'h5, 0, 1, 0, 5'd0, "di_pre_vsync_line");
        chk(b + 8250 + 1614, 3'd7, 4'h0, 0, 1, 0, 5'd0, "di_trail_vsync_line");
        chk(b + 8250 + 1640, 3'd0, 4'h0, 0, 1, 0, 5'd0, "no_vpre_vsync_line");
        chk(b + 9900 + 1284, 3'd0, 4'h0, 0, 1, 0, 5'd0, "no_island_valid_low");
        for (int ln = 0; ln < 6; ln++)
            for (int k = 0; k < 10; k++)
                rdy_q.push_back(b + ln * HT + 1294 + 32 * k);
        pkt_valid = 1'b1;
        wait_cyc(b + 9900);
        pkt_valid = 1'b0;

        // Three packets offered on line 7
        b = 13200 + 7 * HT;
        wait_cyc(b + 1000);
        chk(b + 1294, 3'd6, 4'h0, 0, 0, 1, 5'd0,  "three_slot0");
        chk(b + 1358, 3'd6, 4'h0, 0, 0, 1, 5'd0,  "three_slot2");
        chk(b + 1389, 3'd6, 4'h0, 0, 0, 0, 5'd31, "three_slot2_px31");
        chk(b + 1390, 3'd7, 4'h0, 1, 0, 0, 5'd0,  "three_trail_first");
        chk(b + 1391, 3'd7, 4'h0, 1, 0, 0, 5'd0,  "three_trail_last");
        chk(b + 1392, 3'd0, 4'h0, 1, 0, 0, 5'd0,  "three_ctrl");
        chk(b + 1639, 3'd0, 4'h0, 0, 0, 0, 5'd0,  "three_ctrl_end");
        chk(b + 1640, 3'd1, 4'h1, 0, 0, 0, 5'd0,  "three_vid_pre");
        for (int k = 0; k < 3; k++)
            rdy_q.push_back(b + 1294 + 32 * k);
        pkt_valid = 1'b1;
        wait_cyc(b + 1358);
        pkt_valid = 1'b0;

        // Late pkt_valid: no island this line, island next line
        b = 2 * 13200;
        wait_cyc(b);
        chk(b + 1284, 3'd0, 4'h0, 0, 0, 0, 5'd0, "late_no_pre");
        chk(b + 1290, 3'd0, 4'h0, 0, 0, 0, 5'd0, "late_no_pre2");
        chk(b + 1294, 3'd0, 4'h0, 0, 0, 0, 5'd0, "late_no_data");
        chk(b + HT + 1283, 3'd0, 4'h0, 0, 0, 0, 5'd0, "next_before_pre");
        chk(b + HT + 1284, 3'd4, 4'h5, 0, 0, 0, 5'd0, "next_di_pre");
        chk(b + HT + 1358, 3'd6, 4'h0, 0, 0, 1, 5'd0, "next_slot2_px0");
        chk(b + HT + 1359, 3'd6, 4'h0, 0, 0, 0, 5'd1, "next_slot2_px1");
        for (int k = 0; k < 3; k++)
            rdy_q.push_back(b + HT + 1294 + 32 * k);
        wait_cyc(b + 1285);
        pkt_valid = 1'b1;

        // Reset in the middle of slot 2
        wait_cyc(b + HT + 1360);
        chk(-1,   3'd0, 4'h0, 0, 0, 0, 5'd0, "reset_mid_island");
        chk(0,    3'd3, 4'h0, 0, 0, 0, 5'd0, "resume_video_0_0");
        chk(1294, 3'd0, 4'h0, 0, 0, 0, 5'd0, "resume_no_island");
        chk(1650, 3'd3, 4'h0, 0, 0, 0, 5'd0, "resume_video_0_1");
        reset = 1'b1;
        pkt_valid = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 reset = 1'b0;
        wait_cyc(2000);
        repeat (5) @(posedge clk_i);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s actual=not_reached required_cyc=%0d", e.name, e.cyc);
        end
        while (rdy_q.size() > 0) begin
            int r;
            r = rdy_q.pop_front();
            checks++;
            errors++;
            $display("FAIL pkt_ready_missing actual=none required_cyc=%0d", r);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
